// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU datapath blocks.
package cpu_pkg;
  localparam int ADDR_W       = 8;
  localparam int RSTACK_DEPTH = 8;
endpackage

// File: rtl/stack_regfile.sv
// Return-stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_regfile #(
  parameter int WIDTH = cpu_pkg::ADDR_W,
  parameter int DEPTH = cpu_pkg::RSTACK_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/return_stack.sv
// Return-address stack feeding the program counter's load_val/load pair on RET.
// push/pop are single-cycle requests with no ready: push when full is dropped, pop when empty is dropped.
module return_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_val,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_val,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);
  localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]   count_q, count_d, count_m1;
  logic [WIDTH-1:0] pop_val_q, pop_val_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             we;
  logic [PTR_W-1:0] waddr, top_idx;
  logic [WIDTH-1:0] rdata;

  assign count_m1 = count_q - ONE_CNT;
  assign top_idx  = count_m1[PTR_W-1:0];
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);

  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_regfile (
    .clk   (clk),
    .we    (we & ~reset),
    .waddr (waddr),
    .wdata (push_val),
    .raddr (top_idx),
    .rdata (rdata)
  );

  always_comb begin
    count_d     = count_q;
    pop_val_d   = pop_val_q;
    pop_valid_d = 1'b0;
    overflow_d  = clear_err ? 1'b0 : overflow_q;
    underflow_d = clear_err ? 1'b0 : underflow_q;
    we          = 1'b0;
    waddr       = count_q[PTR_W-1:0];
    if (push && pop) begin
      pop_valid_d = 1'b1;
      if (empty) begin
        pop_val_d = push_val;
      end else begin
        // Swap in place: the old top leaves, the new address takes its slot.
        pop_val_d = rdata;
        we        = 1'b1;
        waddr     = top_idx;
      end
    end else if (push) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = count_q + ONE_CNT;
      end
    end else if (pop) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        pop_val_d   = rdata;
        pop_valid_d = 1'b1;
        count_d     = count_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      pop_val_q   <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_val_q   <= pop_val_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign pop_val   = pop_val_q;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign top       = empty ? '0 : rdata;
endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: hand-computed expectations for push/pop/swap/bypass/errors/reset.
module tb_return_stack;
  logic       clk = 1'b0;
  logic       reset, push, pop, clear_err;
  logic [7:0] push_val;
  logic [7:0] pop_val, top;
  logic       pop_valid, empty, full, overflow, underflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  return_stack dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_val  (push_val),
    .pop       (pop),
    .pop_val   (pop_val),
    .pop_valid (pop_valid),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then settle just past the rising edge.
  task automatic step(input logic rst, input logic ps, input logic [7:0] val,
                      input logic pp, input logic clr);
    reset = rst; push = ps; push_val = val; pop = pp; clear_err = clr;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] val);
    step(1'b0, 1'b1, val, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(pop_valid), 32'd1);
    check({tag, "_val"}, 32'(pop_val), 32'(e));
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; push_val = '0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_top", 32'(top), 32'd0);
    check("rst_pop_val", 32'(pop_val), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);

    foreach (exp_q[i]) exp_q.delete();
    do_push(8'h10); check("push1_pv", 32'(pop_valid), 32'd0);
    do_push(8'h20); check("push2_pv", 32'(pop_valid), 32'd0);
    do_push(8'h30); check("push3_pv", 32'(pop_valid), 32'd0);
    check("push3_count", 32'(count), 32'd3);
    check("push3_top", 32'(top), 32'h30);
    check("push3_empty", 32'(empty), 32'd0);
    check("push3_full", 32'(full), 32'd0);

    exp_q.push_back(8'h30); exp_q.push_back(8'h20); exp_q.push_back(8'h10);
    do_pop(); check_pop("pop1");
    do_pop(); check_pop("pop2");
    do_pop(); check_pop("pop3");
    check("pop3_count", 32'(count), 32'd0);
    check("pop3_empty", 32'(empty), 32'd1);
    check("pop3_top", 32'(top), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_pv", 32'(pop_valid), 32'd0);
    check("idle_hold", 32'(pop_val), 32'h10);

    for (int i = 1; i <= 8; i++) do_push(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd0);
    do_push(8'h09);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_top", 32'(top), 32'h08);
    exp_q.push_back(8'h08);
    do_pop(); check_pop("ovf_pop");
    check("ovf_pop_count", 32'(count), 32'd7);
    check("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clear", 32'(overflow), 32'd0);

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    do_push(8'h33);
    do_push(8'h44);
    exp_q.push_back(8'h44);
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0); check_pop("swap");
    check("swap_count", 32'(count), 32'd2);
    check("swap_top", 32'(top), 32'h55);
    check("swap_ovf", 32'(overflow), 32'd0);
    exp_q.push_back(8'h55); exp_q.push_back(8'h33);
    do_pop(); check_pop("swap_pop1");
    do_pop(); check_pop("swap_pop2");
    exp_q.push_back(8'h66);
    step(1'b0, 1'b1, 8'h66, 1'b1, 1'b0); check_pop("bypass");
    check("bypass_count", 32'(count), 32'd0);
    check("bypass_ovf", 32'(overflow), 32'd0);
    check("bypass_unf", 32'(underflow), 32'd0);

    do_pop();
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_pv", 32'(pop_valid), 32'd0);
    check("unf_hold", 32'(pop_val), 32'h66);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clear", 32'(underflow), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("unf_wins", 32'(underflow), 32'd1);

    do_push(8'h11);
    do_push(8'h22);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_pop_val", 32'(pop_val), 32'd0);
    check("mid_rst_pv", 32'(pop_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_unf", 32'(underflow), 32'd0);
    check("mid_rst_top", 32'(top), 32'd0);
    do_pop();
    check("post_rst_unf", 32'(underflow), 32'd1);
    check("post_rst_pv", 32'(pop_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
